hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
//  Parametrised ID-stage hazard and forwarding controller for the ARM pipeline. Generalises the
//  fixed EXE/MEM compare to DEPTH tracked stages and NUM_SRC operands. Keeps an internal shadow
//  pipeline of in-flight destinations, and produces three things: a stall request, per-source
//  forward selects and a saturating stall counter. Sits beside the ID stage and drives the
//  IF/ID freeze and the ID/EXE bubble insert.
// PARAMETERS
//  REG_AW   4   register-address width (16 architectural registers)
//  NUM_SRC  2   source operands checked per instruction (1..4)
//  DEPTH    2   tracked producer stages; stage 0 = EXE, stage DEPTH-1 = last stage before WB (1..6)
//  FWD_EN   1   1: resolve matches by forwarding where legal; 0: every match stalls
//  CNT_W    16  stall counter width
//  localparam SEL_W = $clog2(DEPTH+1)
// PORTS
//  clk             in   1                clock, rising edge
//  rst_n           in   1                asynchronous reset, active low
//  id_valid        in   1                ID holds a real instruction
//  id_src          in   NUM_SRC*REG_AW   source register addresses, source i at [i*REG_AW +: REG_AW]
//  id_src_vld      in   NUM_SRC          source i is actually read
//  id_dest         in   REG_AW           destination register of the ID instruction
//  id_wb_en        in   1                ID instruction writes id_dest
//  id_is_load      in   1                ID instruction is a load (data ready only after MEM)
//  freeze          in   1                whole pipeline held (e.g. memory wait)
//  flush           in   1                branch taken: all younger in-flight ops killed
//  hazard_detected out  1                stall ID and insert a bubble into EXE
//  fwd_sel         out  NUM_SRC*SEL_W    per source: 0 = register file, k = forward from stage k-1
//  stall_cnt       out  CNT_W            saturating count of stall cycles
// BEHAVIOUR
//  Shadow stage entry: {vld, dest, load}. Reset (async, rst_n=0): all entries vld=0,
//   stall_cnt=0. hazard_detected=0 and fwd_sel=0 therefore hold throughout reset.
//  Match rule: source i matches stage k when all of these hold:
//   - id_valid=1 and id_src_vld[i]=1
//   - stage k vld=1
//   - stage k dest == id_src[i]
//  When several stages match, only the youngest (lowest k) counts.
//  Per-source resolution, using the youngest match k:
//   - no match: fwd_sel_i=0, no stall.
//   - FWD_EN=0: stall.
//   - FWD_EN=1, k=0 with load=1: stall (load-use hazard).
//   - otherwise: fwd_sel_i=k+1, no stall.
//  hazard_detected = OR over sources of the stall condition. It is combinational from the
//   current inputs and state, in the same cycle (zero latency).
//  While hazard_detected=1, every fwd_sel_i is forced to 0.
//  Shadow update on each rising edge, first matching priority wins:
//   1. flush=1: all stages vld=0.
//   2. freeze=1: all stages hold.
//   3. hazard_detected=1: stages shift (k -> k+1, DEPTH-1 retires); stage 0 gets vld=0 (bubble).
//   4. else: stages shift; stage 0 <= {id_valid & id_wb_en, id_dest, id_is_load}.
//  Simultaneous events:
//   - flush+freeze: flush wins.
//   - flush+hazard: flush wins; no bubble accounting.
//   - hazard_detected still evaluates during freeze, but the state holds.
//  stall_cnt: +1 on each edge with hazard_detected=1, freeze=0 and flush=0. Saturates at
//   all-ones and never wraps. Cleared only by reset.
//  An instruction with id_wb_en=0 enters as an invalid entry and never causes a match.
//  Same-register src/dest in the ID instruction itself is not a hazard.
//  Reset asserted mid-stall clears everything immediately. The first edge after release sees
//   an empty shadow.
// TESTING
//  1. Reset, then ADD r3 issues; next cycle src0=r3 -> hazard=0, fwd_sel0=1. Same case with
//     FWD_EN=0 -> hazard=1 for exactly 2 cycles (DEPTH=2), then fwd_sel0=0.
//  2. LDR r5, then src1=r5 on the next cycle -> hazard=1 for 1 cycle, then fwd_sel1=2,
//     stall_cnt=1.
//  3. r2 written at stage0 and stage1, src0=r2 -> fwd_sel0=1 (youngest wins).
//     id_src_vld0=0 -> fwd_sel0=0, hazard=0.
//  4. Load-use hazard pending with flush=1 the same cycle -> next cycle all entries cleared,
//     hazard=0, stall_cnt unchanged. Repeat with freeze=1 -> state and stall_cnt held.
//  5. CNT_W=4, force 20 stall cycles -> stall_cnt stops at 15.
//     rst_n low mid-stall -> stall_cnt=0 and hazard=0 immediately.
//  6. NUM_SRC=3, DEPTH=4: randomised issue stream vs. reference model. Check hazard and
//     fwd_sel every cycle.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// ID-stage hazard/forwarding controller: tracks DEPTH in-flight destinations and
// resolves each source operand to a forward select or a stall request.
module hazard_forward_unit #(
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned FWD_EN  = 1,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned SEL_W  = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]  id_src,
  input  logic [NUM_SRC-1:0]         id_src_vld,
  input  logic [REG_AW-1:0]          id_dest,
  input  logic                       id_wb_en,
  input  logic                       id_is_load,
  input  logic                       freeze,
  input  logic                       flush,
  output logic                       hazard_detected,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic [CNT_W-1:0]           stall_cnt
);

  logic [DEPTH-1:0]  sh_vld;
  logic [DEPTH-1:0]  sh_load;
  logic [REG_AW-1:0] sh_dest [DEPTH];

  logic [NUM_SRC-1:0] src_hit;
  logic [NUM_SRC-1:0] src_stall;
  logic [SEL_W-1:0]   src_sel [NUM_SRC];

  // Ascending scan with a hit flag so the youngest matching stage wins.
  always_comb begin
    src_hit   = '0;
    src_stall = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_sel[i] = '0;
      if (id_valid && id_src_vld[i]) begin
        for (int unsigned j = 0; j < DEPTH; j++) begin
          if (!src_hit[i] && sh_vld[j] && (sh_dest[j] == id_src[i*REG_AW +: REG_AW])) begin
            src_hit[i]   = 1'b1;
            src_sel[i]   = SEL_W'(j + 1);
            src_stall[i] = (FWD_EN == 0) || ((j == 0) && sh_load[0]);
          end
        end
      end
    end
    hazard_detected = |src_stall;
  end

  always_comb begin
    fwd_sel = '0;
    if (!hazard_detected) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        fwd_sel[i*SEL_W +: SEL_W] = src_sel[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_vld    <= '0;
      sh_load   <= '0;
      stall_cnt <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        sh_dest[k] <= '0;
      end
    end else begin
      if (flush) begin
        sh_vld <= '0;
      end else if (!freeze) begin
        for (int unsigned k = 1; k < DEPTH; k++) begin
          sh_vld[k]  <= sh_vld[k-1];
          sh_dest[k] <= sh_dest[k-1];
          sh_load[k] <= sh_load[k-1];
        end
        sh_vld[0]  <= id_valid & id_wb_en & ~hazard_detected;
        sh_dest[0] <= id_dest;
        sh_load[0] <= id_is_load;
      end
      if (hazard_detected && !freeze && !flush && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed scenarios on small configurations plus a
// randomised issue stream on a 3-source, 4-stage instance against a queue model.
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_wb_en, id_is_load, freeze, flush;
  logic [3:0]  id_dest;
  logic [7:0]  src2;
  logic [1:0]  vld2;
  logic [11:0] src3;
  logic [2:0]  vld3;

  logic        a_haz, b_haz, c_haz, d_haz;
  logic [3:0]  a_fwd, b_fwd, c_fwd;
  logic [8:0]  d_fwd;
  logic [15:0] a_cnt, b_cnt, d_cnt;
  logic [3:0]  c_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {logic vld; logic [3:0] dest; logic ld;} ent_t;
  ent_t mq[$];

  always #5 clk = ~clk;

  hazard_forward_unit u_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(src2), .id_src_vld(vld2),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_is_load(id_is_load), .freeze(freeze),
    .flush(flush), .hazard_detected(a_haz), .fwd_sel(a_fwd), .stall_cnt(a_cnt));

  hazard_forward_unit #(.FWD_EN(0)) u_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(src2), .id_src_vld(vld2),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_is_load(id_is_load), .freeze(freeze),
    .flush(flush), .hazard_detected(b_haz), .fwd_sel(b_fwd), .stall_cnt(b_cnt));

  hazard_forward_unit #(.CNT_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(src2), .id_src_vld(vld2),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_is_load(id_is_load), .freeze(freeze),
    .flush(flush), .hazard_detected(c_haz), .fwd_sel(c_fwd), .stall_cnt(c_cnt));

  hazard_forward_unit #(.NUM_SRC(3), .DEPTH(4)) u_d (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(src3), .id_src_vld(vld3),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_is_load(id_is_load), .freeze(freeze),
    .flush(flush), .hazard_detected(d_haz), .fwd_sel(d_fwd), .stall_cnt(d_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 0; id_wb_en = 0; id_is_load = 0; freeze = 0; flush = 0;
    id_dest = 0; src2 = 0; vld2 = 0; src3 = 0; vld3 = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic issue(input logic [3:0] dest, input logic ld);
    id_valid = 1; id_dest = dest; id_wb_en = 1; id_is_load = ld; vld2 = 0;
  endtask

  task automatic test_reset();
    idle();
    id_valid = 1; src2 = 8'h11; vld2 = 2'b11; src3 = 12'h111; vld3 = 3'b111;
    rst_n = 0;
    #3;
    total++; if (a_haz !== 1'b0) begin bad++; $display("FAIL reset_haz got=%0b exp=0", a_haz); end
    total++; if (a_fwd !== 4'd0) begin bad++; $display("FAIL reset_fwd got=%0h exp=0", a_fwd); end
    total++; if (a_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", a_cnt); end
    total++; if (d_haz !== 1'b0 || d_fwd !== 9'd0) begin
      bad++; $display("FAIL reset_d got=%0b/%0h exp=0/0", d_haz, d_fwd); end
    tick();
    rst_n = 1;
    idle();
  endtask

  task automatic test_fwd_exe();
    do_reset();
    issue(4'd3, 1'b0);
    tick();
    id_dest = 4'd9; id_wb_en = 0; src2 = {4'd0, 4'd3}; vld2 = 2'b01;
    settle();
    total++; if (a_haz !== 1'b0) begin bad++; $display("FAIL fwd_exe_haz got=%0b exp=0", a_haz); end
    total++; if (a_fwd !== 4'b0001) begin bad++; $display("FAIL fwd_exe_sel got=%0h exp=1", a_fwd); end
    total++; if (b_haz !== 1'b1) begin bad++; $display("FAIL nofwd_c1 got=%0b exp=1", b_haz); end
    tick(); settle();
    total++; if (b_haz !== 1'b1) begin bad++; $display("FAIL nofwd_c2 got=%0b exp=1", b_haz); end
    tick(); settle();
    total++; if (b_haz !== 1'b0) begin bad++; $display("FAIL nofwd_c3 got=%0b exp=0", b_haz); end
    total++; if (b_fwd !== 4'd0) begin bad++; $display("FAIL nofwd_sel got=%0h exp=0", b_fwd); end
    total++; if (b_cnt !== 16'd2) begin bad++; $display("FAIL nofwd_cnt got=%0d exp=2", b_cnt); end
  endtask

  task automatic test_load_use();
    do_reset();
    issue(4'd5, 1'b1);
    tick();
    id_dest = 0; id_wb_en = 0; id_is_load = 0; src2 = {4'd5, 4'd0}; vld2 = 2'b10;
    settle();
    total++; if (a_haz !== 1'b1) begin bad++; $display("FAIL ldu_haz got=%0b exp=1", a_haz); end
    total++; if (a_fwd !== 4'd0) begin bad++; $display("FAIL ldu_sel_forced got=%0h exp=0", a_fwd); end
    tick(); settle();
    total++; if (a_haz !== 1'b0) begin bad++; $display("FAIL ldu_after_haz got=%0b exp=0", a_haz); end
    total++; if (a_fwd !== 4'b1000) begin bad++; $display("FAIL ldu_after_sel got=%0h exp=8", a_fwd); end
    total++; if (a_cnt !== 16'd1) begin bad++; $display("FAIL ldu_cnt got=%0d exp=1", a_cnt); end
  endtask

  task automatic test_youngest();
    do_reset();
    issue(4'd2, 1'b0);
    tick(); tick();
    id_wb_en = 0; src2 = {4'd0, 4'd2}; vld2 = 2'b01;
    settle();
    total++; if (a_fwd !== 4'b0001 || a_haz !== 1'b0) begin
      bad++; $display("FAIL youngest got=%0h/%0b exp=1/0", a_fwd, a_haz); end
    vld2 = 2'b00;
    #1;
    total++; if (a_fwd !== 4'd0 || a_haz !== 1'b0) begin
      bad++; $display("FAIL src_not_read got=%0h/%0b exp=0/0", a_fwd, a_haz); end
    do_reset();
    issue(4'd7, 1'b0);
    src2 = {4'd0, 4'd7}; vld2 = 2'b01;
    settle();
    total++; if (a_haz !== 1'b0 || a_fwd !== 4'd0) begin
      bad++; $display("FAIL self_dep got=%0b/%0h exp=0/0", a_haz, a_fwd); end
    tick();
    id_wb_en = 0;
    settle();
    total++; if (a_fwd !== 4'b0001) begin bad++; $display("FAIL self_next got=%0h exp=1", a_fwd); end
  endtask

  task automatic test_flush_freeze();
    do_reset();
    issue(4'd5, 1'b1);
    tick();
    id_wb_en = 0; id_is_load = 0; src2 = {4'd0, 4'd5}; vld2 = 2'b01; flush = 1;
    settle();
    total++; if (a_haz !== 1'b1) begin bad++; $display("FAIL flush_pre got=%0b exp=1", a_haz); end
    tick();
    flush = 0;
    settle();
    total++; if (a_haz !== 1'b0 || a_fwd !== 4'd0) begin
      bad++; $display("FAIL flush_clr got=%0b/%0h exp=0/0", a_haz, a_fwd); end
    total++; if (a_cnt !== 16'd0) begin bad++; $display("FAIL flush_cnt got=%0d exp=0", a_cnt); end

    do_reset();
    issue(4'd5, 1'b1);
    tick();
    id_wb_en = 0; id_is_load = 0; src2 = {4'd0, 4'd5}; vld2 = 2'b01; freeze = 1;
    tick(); settle();
    total++; if (a_haz !== 1'b1) begin bad++; $display("FAIL freeze_hold got=%0b exp=1", a_haz); end
    total++; if (a_cnt !== 16'd0) begin bad++; $display("FAIL freeze_cnt got=%0d exp=0", a_cnt); end
    freeze = 0;
    tick(); settle();
    total++; if (a_haz !== 1'b0 || a_fwd !== 4'b0010) begin
      bad++; $display("FAIL freeze_rel got=%0b/%0h exp=0/2", a_haz, a_fwd); end
    total++; if (a_cnt !== 16'd1) begin bad++; $display("FAIL freeze_rel_cnt got=%0d exp=1", a_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    issue(4'd5, 1'b1);
    src2 = {4'd0, 4'd5}; vld2 = 2'b01;
    // Alternates stall / forward each cycle: 41 edges give 20 stalls and end with a stall pending.
    repeat (41) tick();
    settle();
    total++; if (c_cnt !== 4'd15) begin bad++; $display("FAIL sat_cnt got=%0d exp=15", c_cnt); end
    total++; if (a_cnt !== 16'd20) begin bad++; $display("FAIL wide_cnt got=%0d exp=20", a_cnt); end
    total++; if (c_haz !== 1'b1) begin bad++; $display("FAIL sat_haz got=%0b exp=1", c_haz); end
    #2;
    rst_n = 0;
    #1;
    total++; if (c_cnt !== 4'd0 || c_haz !== 1'b0) begin
      bad++; $display("FAIL midreset got=%0d/%0b exp=0/0", c_cnt, c_haz); end
    tick();
    rst_n = 1;
    idle();
  endtask

  task automatic test_random();
    logic        exp_haz;
    logic [8:0]  exp_fwd;
    logic [15:0] exp_cnt;
    logic [3:0]  s;
    int          k;
    do_reset();
    mq = {};
    for (int n = 0; n < 4; n++) mq.push_back('0);
    exp_cnt = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      id_valid   = ($urandom_range(0, 9) != 0);
      src3       = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      vld3       = 3'($urandom);
      id_dest    = 4'($urandom_range(0, 3));
      id_wb_en   = 1'($urandom);
      id_is_load = ($urandom_range(0, 2) == 0);
      flush      = ($urandom_range(0, 19) == 0);
      freeze     = ($urandom_range(0, 9) == 0);

      exp_haz = 0;
      exp_fwd = 0;
      for (int i = 0; i < 3; i++) begin
        s = src3[i*4 +: 4];
        k = -1;
        if (id_valid && vld3[i])
          for (int j = 3; j >= 0; j--) if (mq[j].vld && mq[j].dest == s) k = j;
        if (k == 0 && mq[0].ld) exp_haz = 1;
        else if (k >= 0) exp_fwd[i*3 +: 3] = 3'(k + 1);
      end
      if (exp_haz) exp_fwd = 0;

      settle();
      total++; if (d_haz !== exp_haz) begin
        bad++; $display("FAIL rand_haz cyc=%0d got=%0b exp=%0b", cyc, d_haz, exp_haz); end
      total++; if (d_fwd !== exp_fwd) begin
        bad++; $display("FAIL rand_fwd cyc=%0d got=%0h exp=%0h", cyc, d_fwd, exp_fwd); end

      if (flush) begin
        for (int j = 0; j < 4; j++) mq[j].vld = 0;
      end else if (!freeze) begin
        mq.push_front(exp_haz ? ent_t'(0) : ent_t'{id_valid & id_wb_en, id_dest, id_is_load});
        void'(mq.pop_back());
        if (exp_haz) exp_cnt++;
      end
      tick();
    end
    total++; if (d_cnt !== exp_cnt) begin
      bad++; $display("FAIL rand_cnt got=%0d exp=%0d", d_cnt, exp_cnt); end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1;
    idle();
    test_reset();
    test_fwd_exe();
    test_load_use();
    test_youngest();
    test_flush_freeze();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
